// File: rtl/game_controller.sv
// Minesweeper sequencer: latches geometry, runs the filler handshake, serves open/flag commands,
// owns the revealed/flagged bitmaps and performs raster-sweep flood fill through the field read port.
`default_nettype none

module game_controller #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16,
  parameter int CELL_X_WIDTH    = $clog2(MAX_CELL_WIDTH),
  parameter int CELL_Y_WIDTH    = $clog2(MAX_CELL_HEIGHT),
  parameter int MINES_W         = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT/4),
  parameter int CNT_W           = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT+1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          new_game_i,
  input  logic [CELL_X_WIDTH-1:0]                       width_i,
  input  logic [CELL_Y_WIDTH-1:0]                       height_i,
  input  logic [MINES_W-1:0]                            mines_i,
  output logic                                          fill_start_o,
  output logic [CELL_X_WIDTH-1:0]                       fill_width_o,
  output logic [CELL_Y_WIDTH-1:0]                       fill_height_o,
  output logic [MINES_W-1:0]                            fill_mines_o,
  input  logic                                          fill_finished_i,
  output logic [CELL_X_WIDTH-1:0]                       rd_x_o,
  output logic [CELL_Y_WIDTH-1:0]                       rd_y_o,
  input  logic [3:0]                                    rd_data_i,
  input  logic                                          cmd_valid_i,
  output logic                                          cmd_ready_o,
  input  logic                                          cmd_op_i,
  input  logic [CELL_X_WIDTH-1:0]                       cmd_x_i,
  input  logic [CELL_Y_WIDTH-1:0]                       cmd_y_i,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0] revealed_o,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0] flagged_o,
  output logic [CNT_W-1:0]                              revealed_cnt_o,
  output logic                                          busy_o,
  output logic                                          game_won_o,
  output logic                                          game_lost_o
);

  typedef enum logic [2:0] {IDLE, FILL, PLAY, READ, SWEEP, WON, LOST} state_t;

  state_t                  state;
  logic [CELL_X_WIDTH-1:0] cur_x, scan_x, p_x;
  logic [CELL_Y_WIDTH-1:0] cur_y, scan_y, p_y;
  logic                    p_valid, issue_done, changed;

  logic [CNT_W-1:0] area, target;
  logic             cmd_in_range, scan_last, p_last;
  logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0] spread;
  logic [3:0]       spread_cnt;
  int               nx, ny;

  assign area         = CNT_W'(fill_width_o) * CNT_W'(fill_height_o);
  assign target       = area - CNT_W'(fill_mines_o);
  assign cmd_in_range = (cmd_x_i < fill_width_o) && (cmd_y_i < fill_height_o);
  assign scan_last    = (scan_x == fill_width_o - CELL_X_WIDTH'(1)) &&
                        (scan_y == fill_height_o - CELL_Y_WIDTH'(1));
  assign p_last       = (p_x == fill_width_o - CELL_X_WIDTH'(1)) &&
                        (p_y == fill_height_o - CELL_Y_WIDTH'(1));

  // The command address goes straight to the field so its data is ready in READ.
  assign rd_x_o       = (state == PLAY) ? cmd_x_i : scan_x;
  assign rd_y_o       = (state == PLAY) ? cmd_y_i : scan_y;

  assign cmd_ready_o  = (state == PLAY);
  assign busy_o       = (state == FILL) || (state == READ) || (state == SWEEP);
  assign game_won_o   = (state == WON);
  assign game_lost_o  = (state == LOST);

  // Neighbours newly revealed by the sweep cell whose data arrives this cycle.
  always_comb begin
    spread     = '0;
    spread_cnt = '0;
    nx         = 0;
    ny         = 0;
    if (state == SWEEP && p_valid && revealed_o[p_x][p_y] && rd_data_i == 4'd0) begin
      for (int dx = -1; dx <= 1; dx++) begin
        for (int dy = -1; dy <= 1; dy++) begin
          nx = int'(p_x) + dx;
          ny = int'(p_y) + dy;
          if ((dx != 0 || dy != 0) && nx >= 0 && ny >= 0 &&
              nx < int'(fill_width_o) && ny < int'(fill_height_o)) begin
            if (!revealed_o[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] &&
                !flagged_o[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]]) begin
              spread[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] = 1'b1;
              spread_cnt = spread_cnt + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fill_start_o   <= 1'b0;
      fill_width_o   <= '0;
      fill_height_o  <= '0;
      fill_mines_o   <= '0;
      revealed_o     <= '0;
      flagged_o      <= '0;
      revealed_cnt_o <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      scan_x         <= '0;
      scan_y         <= '0;
      p_x            <= '0;
      p_y            <= '0;
      p_valid        <= 1'b0;
      issue_done     <= 1'b0;
      changed        <= 1'b0;
    end else begin
      fill_start_o <= 1'b0;
      if (new_game_i) begin
        fill_width_o   <= width_i;
        fill_height_o  <= height_i;
        fill_mines_o   <= mines_i;
        revealed_o     <= '0;
        flagged_o      <= '0;
        revealed_cnt_o <= '0;
        fill_start_o   <= 1'b1;
        p_valid        <= 1'b0;
        state          <= FILL;
      end else begin
        case (state)
          FILL: if (fill_finished_i) state <= PLAY;
          PLAY: begin
            if (cmd_valid_i && cmd_in_range && !revealed_o[cmd_x_i][cmd_y_i]) begin
              if (cmd_op_i) begin
                flagged_o[cmd_x_i][cmd_y_i] <= ~flagged_o[cmd_x_i][cmd_y_i];
              end else if (!flagged_o[cmd_x_i][cmd_y_i]) begin
                cur_x <= cmd_x_i;
                cur_y <= cmd_y_i;
                state <= READ;
              end
            end
          end
          READ: begin
            revealed_o[cur_x][cur_y] <= 1'b1;
            if (rd_data_i == 4'd9) begin
              state <= LOST;
            end else begin
              revealed_cnt_o <= revealed_cnt_o + CNT_W'(1);
              if (rd_data_i != 4'd0) begin
                state <= ((revealed_cnt_o + CNT_W'(1)) == target) ? WON : PLAY;
              end else begin
                scan_x     <= '0;
                scan_y     <= '0;
                p_valid    <= 1'b0;
                issue_done <= 1'b0;
                changed    <= 1'b0;
                state      <= SWEEP;
              end
            end
          end
          SWEEP: begin
            revealed_o     <= revealed_o | spread;
            revealed_cnt_o <= revealed_cnt_o + CNT_W'(spread_cnt);
            p_valid        <= !issue_done;
            p_x            <= scan_x;
            p_y            <= scan_y;
            if (!issue_done) begin
              if (scan_last) begin
                issue_done <= 1'b1;
              end else if (scan_x == fill_width_o - CELL_X_WIDTH'(1)) begin
                scan_x <= '0;
                scan_y <= scan_y + CELL_Y_WIDTH'(1);
              end else begin
                scan_x <= scan_x + CELL_X_WIDTH'(1);
              end
            end
            if (spread_cnt != 4'd0) changed <= 1'b1;
            // Last cell of the pass evaluated: rescan if anything changed, else settle.
            if (p_valid && p_last) begin
              if (changed || spread_cnt != 4'd0) begin
                changed    <= 1'b0;
                scan_x     <= '0;
                scan_y     <= '0;
                issue_done <= 1'b0;
                p_valid    <= 1'b0;
              end else begin
                state <= (revealed_cnt_o == target) ? WON : PLAY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller with a behavioural field memory and filler handshake.
`default_nettype none

module tb_game_controller;

  logic              clk = 1'b0;
  logic              rst;
  logic              new_game;
  logic [4:0]        width;
  logic [3:0]        height;
  logic [6:0]        mines;
  logic              fill_start;
  logic [4:0]        fill_width;
  logic [3:0]        fill_height;
  logic [6:0]        fill_mines;
  logic              fill_finished;
  logic [4:0]        rd_x;
  logic [3:0]        rd_y;
  logic [3:0]        rd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [4:0]        cmd_x;
  logic [3:0]        cmd_y;
  logic [29:0][15:0] revealed;
  logic [29:0][15:0] flagged;
  logic [8:0]        revealed_cnt;
  logic              busy;
  logic              won;
  logic              lost;

  game_controller dut (
    .clk(clk), .rst(rst), .new_game_i(new_game), .width_i(width), .height_i(height),
    .mines_i(mines), .fill_start_o(fill_start), .fill_width_o(fill_width),
    .fill_height_o(fill_height), .fill_mines_o(fill_mines), .fill_finished_i(fill_finished),
    .rd_x_o(rd_x), .rd_y_o(rd_y), .rd_data_i(rd_data), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_x_i(cmd_x), .cmd_y_i(cmd_y),
    .revealed_o(revealed), .flagged_o(flagged), .revealed_cnt_o(revealed_cnt),
    .busy_o(busy), .game_won_o(won), .game_lost_o(lost)
  );

  always #5 clk = ~clk;

  logic [3:0] field [0:29][0:15];
  always @(posedge clk) rd_data <= (rd_x < 5'd30) ? field[rd_x][rd_y] : 4'd0;

  typedef struct {
    string tag;
    int    cnt;
    bit    won;
    bit    lost;
    bit    ready;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Single-mine field model: 9 at the mine, 1 around it, 0 elsewhere.
  task automatic load_field(input int mx, input int my, input int w, input int h);
    for (int x = 0; x < 30; x++)
      for (int y = 0; y < 16; y++) begin
        field[x][y] = 4'd0;
        if (x < w && y < h) begin
          if (x == mx && y == my) field[x][y] = 4'd9;
          else if (x >= mx-1 && x <= mx+1 && y >= my-1 && y <= my+1) field[x][y] = 4'd1;
        end
      end
  endtask

  task automatic pulse_new_game(input int w, input int h, input int m);
    new_game = 1'b1;
    width    = 5'(w);
    height   = 4'(h);
    mines    = 7'(m);
    @(posedge clk); #1;
    new_game = 1'b0;
    check("fill_start", fill_start, 1);
    check("busy_fill", busy, 1);
    check("clr_revealed", revealed, 0);
    check("clr_flagged", flagged, 0);
    check("clr_cnt", revealed_cnt, 0);
    check("fill_width", fill_width, 5'(w));
  endtask

  task automatic start_game(input int w, input int h, input int m);
    pulse_new_game(w, h, m);
    @(posedge clk); #1;
    check("fill_start_pulse", fill_start, 0);
    @(posedge clk); #1;
    check("busy_until_finish", busy, 1);
    fill_finished = 1'b1;
    @(posedge clk); #1;
    fill_finished = 1'b0;
    check("ready_play", cmd_ready, 1);
  endtask

  task automatic send_cmd(input bit op, input int x, input int y);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = 5'(x);
    cmd_y     = 4'(y);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_push(input string tag, input int cnt, input bit w, input bit l, input bit r);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.won = w; e.lost = l; e.ready = r;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle_and_score();
    exp_t e;
    int   n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", busy, 0);
    e = sb_q.pop_front();
    check({e.tag, "_cnt"}, revealed_cnt, e.cnt);
    check({e.tag, "_won"}, won, e.won);
    check({e.tag, "_lost"}, lost, e.lost);
    check({e.tag, "_ready"}, cmd_ready, e.ready);
  endtask

  logic [29:0][15:0] exp_mask;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; new_game = 1'b0; width = '0; height = '0; mines = '0;
    fill_finished = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x = '0; cmd_y = '0;
    load_field(3, 3, 4, 4);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_cnt", revealed_cnt, 0);
    check("rst_fill_width", fill_width, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Flag / drop / single-cell open
    start_game(4, 4, 1);
    send_cmd(1'b1, 2, 2);
    check("flag_no_busy", busy, 0);
    check("flag_set", flagged[2][2], 1);
    send_cmd(1'b0, 2, 2);
    check("open_flagged_no_read", busy, 0);
    check("open_flagged_ready", cmd_ready, 1);
    check("open_flagged_hidden", revealed[2][2], 0);
    send_cmd(1'b1, 2, 2);
    check("flag_clear", flagged[2][2], 0);
    expect_push("out_of_range", 0, 0, 0, 1);
    send_cmd(1'b0, 5, 0);
    wait_idle_and_score();
    expect_push("open_one", 1, 0, 0, 1);
    send_cmd(1'b0, 2, 2);
    wait_idle_and_score();
    check("open_one_bit", revealed[2][2], 1);
    expect_push("reopen", 1, 0, 0, 1);
    send_cmd(1'b0, 2, 2);
    wait_idle_and_score();

    // Flood fill to win
    expect_push("flood", 15, 1, 0, 0);
    send_cmd(1'b0, 0, 0);
    wait_idle_and_score();
    exp_mask = '0;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        if (!(x == 3 && y == 3)) exp_mask[x][y] = 1'b1;
    check("flood_mask", revealed, exp_mask);
    send_cmd(1'b0, 3, 3);
    check("won_holds_cnt", revealed_cnt, 15);
    check("won_holds_lost", lost, 0);

    // Abort a sweep with new_game
    start_game(4, 4, 1);
    send_cmd(1'b0, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("sweep_busy", busy, 1);
    check("sweep_progress", revealed_cnt != 0, 1);
    pulse_new_game(4, 4, 1);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_no_writes", revealed, 0);
    check("abort_cnt", revealed_cnt, 0);
    check("abort_busy", busy, 1);
    fill_finished = 1'b1;
    @(posedge clk); #1;
    fill_finished = 1'b0;
    check("abort_play", cmd_ready, 1);

    // Open a mine
    load_field(1, 1, 4, 4);
    expect_push("mine", 0, 0, 1, 0);
    send_cmd(1'b0, 1, 1);
    wait_idle_and_score();
    check("mine_revealed", revealed[1][1], 1);
    send_cmd(1'b0, 0, 0);
    check("lost_no_cmd", revealed[0][0], 0);
    check("lost_holds", lost, 1);

    // Asynchronous reset mid-sweep
    load_field(3, 3, 4, 4);
    start_game(4, 4, 1);
    send_cmd(1'b0, 0, 0);
    repeat (6) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cnt", revealed_cnt, 0);
    check("arst_revealed", revealed, 0);
    check("arst_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", {busy, cmd_ready, won, lost}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
